// File: rtl/multi_chan_clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional phase field is present when MULTI_CHAN_CLK_DIV_PHASE_EN is defined.
package multi_chan_clk_div_pkg;

   localparam int CFG_COUNTER_WIDTH = 32;

   // Config bundle at the default counter width, as seen by the register block.
   typedef struct packed {
      logic [CFG_COUNTER_WIDTH-1:0] div;
      logic [CFG_COUNTER_WIDTH-1:0] duty;
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
      logic [CFG_COUNTER_WIDTH-1:0] phase;
`endif
   } ch_cfg_t;

   function automatic int chIdxWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/multi_chan_clk_div_chan.sv
// clk_div_chan: one divider channel with active/shadow config applied at the period boundary.
// Phase offset on start/sync is added when MULTI_CHAN_CLK_DIV_PHASE_EN is defined.
module clk_div_chan
   import multi_chan_clk_div_pkg::*;
#(
   parameter int                       COUNTER_WIDTH = CFG_COUNTER_WIDTH,
   parameter logic [COUNTER_WIDTH-1:0] DEFAULT_DIV   = COUNTER_WIDTH'(49)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_run,
   input  logic                     i_start,
   input  logic                     i_sync,
   input  logic                     i_wrEn,
   input  logic [COUNTER_WIDTH-1:0] i_wrDiv,
   input  logic [COUNTER_WIDTH-1:0] i_wrDuty,
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
   input  logic [COUNTER_WIDTH-1:0] i_wrPhase,
`endif
   output logic                     o_tick,
   output logic                     o_level,
   output logic                     o_pending
);

   typedef struct packed {
      logic [COUNTER_WIDTH-1:0] div;
      logic [COUNTER_WIDTH-1:0] duty;
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
      logic [COUNTER_WIDTH-1:0] phase;
`endif
   } chanCfg_t;

   chanCfg_t                 r_active;
   chanCfg_t                 r_shadow;
   logic                     r_pending;
   logic [COUNTER_WIDTH-1:0] r_counter;

   chanCfg_t                 w_wrCfg;
   chanCfg_t                 w_nextCfg;
   logic                     w_atWrap;
   logic                     w_apply;
   logic [COUNTER_WIDTH-1:0] w_startVal;

   always_comb begin
      w_wrCfg      = '0;
      w_wrCfg.div  = i_wrDiv;
      w_wrCfg.duty = i_wrDuty;
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
      w_wrCfg.phase = i_wrPhase;
`endif
   end

   // A stopped channel has no period in flight, so its shadow may land on any clock.
   assign w_atWrap  = i_run && (r_counter == r_active.div);
   assign w_apply   = r_pending && (!i_run || w_atWrap);
   assign w_nextCfg = w_apply ? r_shadow : r_active;

`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
   assign w_startVal = (w_nextCfg.phase < w_nextCfg.div) ? w_nextCfg.phase : w_nextCfg.div;
`else
   assign w_startVal = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_counter <= '0;
         r_active  <= '{div: DEFAULT_DIV, default: '0};
         r_shadow  <= '0;
         r_pending <= 1'b0;
      end else begin
         r_active <= w_nextCfg;
         if (i_wrEn) begin
            r_shadow  <= w_wrCfg;
            r_pending <= 1'b1;
         end else if (w_apply) begin
            r_pending <= 1'b0;
         end
         if (!i_run) begin
            r_counter <= i_start ? w_startVal : '0;
         end else if (i_sync) begin
            r_counter <= w_startVal;
         end else if (w_atWrap) begin
            r_counter <= '0;
         end else begin
            r_counter <= r_counter + 1'b1;
         end
      end
   end

   assign o_tick    = i_run && (r_counter == '0);
   assign o_level   = i_run && (r_counter < r_active.duty);
   assign o_pending = r_pending;

endmodule

// File: rtl/multi_chan_clk_div.sv
// multi_chan_clk_div: NUM_CH programmable tick/PWM dividers behind one valid/ready config port.
// Define MULTI_CHAN_CLK_DIV_PHASE_EN to add the cfg_phase port and per-channel phase offset.
module multi_chan_clk_div
   import multi_chan_clk_div_pkg::*;
#(
   parameter int                       NUM_CH        = 4,
   parameter int                       COUNTER_WIDTH = 32,
   parameter logic [COUNTER_WIDTH-1:0] DEFAULT_DIV   = COUNTER_WIDTH'(49)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CH-1:0]                ch_en,
   input  logic                             sync_i,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [chIdxWidth(NUM_CH)-1:0]    cfg_ch,
   input  logic [COUNTER_WIDTH-1:0]         cfg_div,
   input  logic [COUNTER_WIDTH-1:0]         cfg_duty,
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
   input  logic [COUNTER_WIDTH-1:0]         cfg_phase,
`endif
   output logic [NUM_CH-1:0]                tick_o,
   output logic [NUM_CH-1:0]                level_o,
   output logic [NUM_CH-1:0]                pending_o
);

   localparam int CH_W = chIdxWidth(NUM_CH);

   logic [NUM_CH-1:0] r_runQ;
   logic              w_accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_runQ <= '0;
      end else begin
         r_runQ <= ch_en;
      end
   end

   // Indices with no channel behind them stay ready so the write is swallowed.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending_o[i];
         end
      end
   end

   assign w_accept = cfg_valid & cfg_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clk_div_chan #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .DEFAULT_DIV   (DEFAULT_DIV)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .i_run     (r_runQ[g]),
         .i_start   (ch_en[g] & ~r_runQ[g]),
         .i_sync    (sync_i),
         .i_wrEn    (w_accept && (cfg_ch == CH_W'(g))),
         .i_wrDiv   (cfg_div),
         .i_wrDuty  (cfg_duty),
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
         .i_wrPhase (cfg_phase),
`endif
         .o_tick    (tick_o[g]),
         .o_level   (level_o[g]),
         .o_pending (pending_o[g])
      );
   end

endmodule

// File: doc/multi_chan_clk_div.md
Name: multi_chan_clk_div

Overview:
- Parametrised successor to the single-channel programmable enable divider.
- NUM_CH independent channels. Each produces a one-cycle enable strobe (tick) and a duty-cycle level output (PWM-style) from one system clock.
- Per-channel period and duty are reconfigured at runtime through a valid/ready config port. New values apply glitch-free at the period boundary.
- Sits between the control/register block and timed peripherals (LED PWM, UART baud, ADC sampling enables).

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- COUNTER_WIDTH, 32, width of period/duty/counter values.
- DEFAULT_DIV, 49, period value loaded into every channel at reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync_i  input  1  restarts all running channels' counters together.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when valid&ready.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  input  COUNTER_WIDTH  new period value D; period = D+1 cycles.
- cfg_duty  input  COUNTER_WIDTH  new high count H.
- tick_o  output  NUM_CH  one-cycle enable strobes.
- level_o  output  NUM_CH  duty-cycle level outputs.
- pending_o  output  NUM_CH  shadow config waiting to apply.

Behaviour:
- Reset (async): all counters 0, active div = DEFAULT_DIV, active duty = 0, shadows cleared, pending 0, run_q 0. tick_o, level_o and pending_o all read 0.
- Per channel i, run_q[i] is ch_en[i] registered. While run_q[i]=0:
  - counter is held at 0;
  - tick_o[i]=0 and level_o[i]=0;
  - any pending shadow applies on the next clock.
- While running, counter counts 0..D and wraps to 0 after D.
  - D=0: tick every cycle.
  - D = all-ones: period 2^COUNTER_WIDTH cycles, no overflow error.
- tick_o[i] = run_q[i] & (counter==0). It is a combinational decode of registered state, with no extra latency.
  - First tick appears in the first cycle after the edge where ch_en is sampled high.
- level_o[i] = run_q[i] & (counter < H).
  - H=0: always low.
  - H>D: always high.
  - Output is registered-state based, so glitch-free.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch].
  - Accept (valid&ready) writes cfg_div/cfg_duty into the shadow of cfg_ch and sets pending.
  - Out-of-range cfg_ch (>= NUM_CH): accepted and discarded.
- Apply: shadow is copied to active, and pending cleared, on the clock where a running channel's counter==active D (wrap edge), or on any clock while stopped.
  - The new period starts at counter 0.
  - Pending is never cleared mid-period.
- sync_i: every running channel's counter loads 0 on the next edge.
  - sync coincident with wrap: counter 0, pending still applies.
  - sync with a channel stopped: no effect on that channel.
- ch_en falling mid-period: counter returns to 0 next edge; no partial tick.
- Reset asserted mid-operation: immediate return to reset values; pending configs are lost.

Optional Feature:
- Macro MULTI_CHAN_CLK_DIV_PHASE_EN.
- When defined:
  - adds port cfg_phase input COUNTER_WIDTH, with a per-channel shadow/active phase P applied with the same rules as div/duty;
  - sync_i and channel start (run_q rising) load the counter with min(P, D) instead of 0, giving programmable inter-channel phase offset.
- When undefined: port absent; start and sync always load 0.

Decomposition:
- Package multi_chan_clk_div_pkg holds:
  - ch_cfg_t struct {div, duty[, phase]}, parameterised via a COUNTER_WIDTH localparam default;
  - the channel-index width function.
- Natural sub-module clk_div_chan: one channel's counter, active/shadow registers, apply logic and tick/level decode, instantiated NUM_CH times by generate.
- Top level holds the handshake decode and the run_q/sync fan-out.

Test Plan:
- Reset, then ch_en=4'b0001 with DEFAULT_DIV=49 -> tick_o[0] pulses every 50 cycles; level_o[0]=0; other channels are silent.
- Write ch1 D=3 H=2, enable -> tick_o[1] every 4 cycles; level_o[1] high 2 cycles, low 2.
- Mid-period write ch0 D=9 H=5 -> pending_o[0]=1 and cfg_ready low for ch0 until the wrap edge; next period is exactly 10 cycles.
- D=0 H=0 then H=1 -> tick every cycle; level constant 0 then constant 1.
- Run ch0 D=4 and ch2 D=6, pulse sync_i -> both tick in the same cycle after sync; with PHASE_EN and ch2 P=3, ch2 ticks 4 cycles after ch0.
- Assert reset mid-period with pending config -> outputs 0 immediately; after release, the channel runs at DEFAULT_DIV and the pending config is discarded.
